// File: rtl/vec_mem_sequencer.sv
// MEM-stage vector sequencer: walks one RAM element per cycle for vector or
// scalar loads/stores, freezing the pipeline while a command is in flight.
module vec_mem_sequencer #(
  parameter int ADDR_W = 19,
  parameter int ELEM_W = 16,
  parameter int LANES  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_load,
  input  logic                    start_store,
  input  logic                    scalar_mode,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [4:0]              rd_in,
  input  logic [LANES*ELEM_W-1:0] store_data,
  input  logic [ELEM_W-1:0]       mem_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  output logic                    mem_wren,
  output logic [LANES*ELEM_W-1:0] load_data,
  output logic [4:0]              load_rd,
  output logic                    load_valid,
  output logic                    done,
  output logic                    busy,
  output logic                    stall,
  output logic [31:0]             access_count
);

  localparam int VEC_W  = LANES * ELEM_W;
  localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STORE      = 3'd1,
    LOAD_ISSUE = 3'd2,
    LOAD_DRAIN = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] cap_base;
  logic [4:0]        cap_rd;
  logic [VEC_W-1:0]  cap_data;
  logic              cap_scalar;
  logic              cap_load;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_inc;
  logic [BEAT_W-1:0] last_beat;
  logic              issue_last;
  logic              accept;
  logic              drain_done;

  // Read-return tracker: stage k holds the beat issued k+1 cycles ago.
  logic [RD_LAT-1:0] rd_vld;
  logic [BEAT_W-1:0] rd_lane [RD_LAT];
  logic [VEC_W-1:0]  rd_buf;
  logic [VEC_W-1:0]  rd_buf_next;

  // Command handshake: a start is taken only in IDLE; stall rises in that same
  // cycle and stays high until the command reaches DONE, so the pipeline holds
  // the issuing instruction. Starts seen while busy are dropped, never queued.
  assign accept     = (state == IDLE) && (start_load || start_store);
  assign last_beat  = cap_scalar ? '0 : BEAT_W'(LANES - 1);
  assign issue_last = (beat == last_beat);
  assign beat_inc   = beat + BEAT_W'(1);
  assign drain_done = rd_vld[RD_LAT-1] && (rd_lane[RD_LAT-1] == last_beat);

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign load_valid = (state == DONE) && cap_load;
  assign stall      = accept || ((state != IDLE) && (state != DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_load) begin
          state_next = LOAD_ISSUE;
        end else if (start_store) begin
          state_next = STORE;
        end
      end
      STORE:      if (issue_last) state_next = DONE;
      LOAD_ISSUE: if (issue_last) state_next = LOAD_DRAIN;
      LOAD_DRAIN: if (drain_done) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_buf_next = rd_buf;
    if (rd_vld[RD_LAT-1]) begin
      rd_buf_next[int'(rd_lane[RD_LAT-1])*ELEM_W +: ELEM_W] = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        rd_lane[k] <= '0;
      end
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        rd_vld[k]  <= rd_vld[k-1];
        rd_lane[k] <= rd_lane[k-1];
      end
      rd_vld[0]  <= (state == LOAD_ISSUE);
      rd_lane[0] <= beat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_base     <= '0;
      cap_rd       <= '0;
      cap_data     <= '0;
      cap_scalar   <= 1'b0;
      cap_load     <= 1'b0;
      beat         <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wren     <= 1'b0;
      rd_buf       <= '0;
      load_data    <= '0;
      load_rd      <= '0;
      access_count <= '0;
    end else begin
      rd_buf <= rd_buf_next;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_base   <= base_addr;
            cap_rd     <= rd_in;
            cap_data   <= store_data;
            cap_scalar <= scalar_mode;
            cap_load   <= start_load;
            beat       <= '0;
            mem_addr   <= base_addr;
            mem_wren   <= !start_load;
            rd_buf     <= '0;
            if (!start_load) begin
              mem_wdata <= store_data[ELEM_W-1:0];
            end
          end
        end
        STORE, LOAD_ISSUE: begin
          if (issue_last) begin
            mem_wren <= 1'b0;
          end else begin
            beat     <= beat_inc;
            mem_addr <= cap_base + ADDR_W'(beat_inc);
            if (state == STORE) begin
              mem_wdata <= cap_data[int'(beat_inc)*ELEM_W +: ELEM_W];
            end
          end
        end
        default: ;
      endcase
      // Results and the command count land on the edge entering DONE so they
      // are already visible while done/load_valid pulse.
      if (state_next == DONE) begin
        access_count <= access_count + 32'd1;
        if (cap_load) begin
          load_data <= rd_buf_next;
          load_rd   <= cap_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: a command-level timing model plus a RAM model
// with configurable read latency, directed corner cases and random traffic.
module tb_vec_mem_sequencer;

  localparam int ADDR_W = 19;
  localparam int ELEM_W = 16;
  localparam int LANES  = 16;
  localparam int RD_LAT = 2;
  localparam int VW     = LANES * ELEM_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_load = 1'b0;
  logic              start_store = 1'b0;
  logic              scalar_mode = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [4:0]        rd_in = '0;
  logic [VW-1:0]     store_data = '0;
  logic [ELEM_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [VW-1:0]     load_data;
  logic [4:0]        load_rd;
  logic              load_valid;
  logic              done;
  logic              busy;
  logic              stall;
  logic [31:0]       access_count;

  vec_mem_sequencer #(
    .ADDR_W(ADDR_W), .ELEM_W(ELEM_W), .LANES(LANES), .RD_LAT(RD_LAT)
  ) u_dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_store(start_store),
    .scalar_mode(scalar_mode), .base_addr(base_addr), .rd_in(rd_in),
    .store_data(store_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .load_data(load_data),
    .load_rd(load_rd), .load_valid(load_valid), .done(done), .busy(busy),
    .stall(stall), .access_count(access_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM environment ----------------
  logic [15:0] env_ram [int];
  logic [15:0] model_mem [int];
  logic [15:0] rpipe [RD_LAT];

  function automatic logic [15:0] env_word(input int a);
    return env_ram.exists(a) ? env_ram[a] : a[15:0];
  endfunction

  function automatic logic [15:0] model_word(input int a);
    return model_mem.exists(a) ? model_mem[a] : a[15:0];
  endfunction

  always @(posedge clk) begin
    rpipe[0] <= env_word(int'(mem_addr));
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    if (mem_wren) env_ram[int'(mem_addr)] = mem_wdata;
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  // ---------------- command-level model ----------------
  bit              m_active = 1'b0;
  int              m_t = 0;
  int              m_len = 0;
  int              m_n = 0;
  bit              m_load = 1'b0;
  logic [ADDR_W-1:0] m_base = '0;
  logic [4:0]      m_rd = '0;
  logic [VW-1:0]   m_data = '0;
  logic [VW-1:0]   m_vec = '0;
  int              m_count = 0;
  logic [VW-1:0]   m_held = '0;
  logic [4:0]      m_held_rd = '0;

  function automatic bit model_busy(input int c);
    return m_active && (c >= m_t + 1) && (c <= m_t + m_len);
  endfunction

  task automatic model_accept();
    logic [ADDR_W-1:0] a;
    if (rst && !model_busy(cyc) && (start_load || start_store)) begin
      m_active = 1'b1;
      m_t      = cyc;
      m_load   = start_load;
      m_base   = base_addr;
      m_rd     = rd_in;
      m_data   = store_data;
      m_n      = scalar_mode ? 1 : LANES;
      m_len    = start_load ? m_n + RD_LAT + 1 : m_n + 1;
      m_vec    = '0;
      for (int i = 0; i < m_n; i++) begin
        a = m_base + ADDR_W'(i);
        m_vec[i*ELEM_W +: ELEM_W] = model_word(int'(a));
      end
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  int last_done_cyc = -1;
  int wren_cycles = 0;
  int stall_cycles = 0;

  always @(negedge clk) begin : cmp
    int d;
    bit inb;
    bit e_done;
    logic [ADDR_W-1:0] ea;
    if (!rst) begin
      chk("rst_load_data", load_data, '0);
      chk("rst_ctl", VW'({mem_addr, mem_wdata, mem_wren, load_rd, load_valid,
                          done, busy, stall, access_count}), '0);
    end else begin
      d      = cyc - m_t;
      inb    = m_active && d >= 1 && d <= m_len;
      e_done = m_active && d == m_len;
      if (e_done) begin
        m_count++;
        if (m_load) begin
          m_held    = m_vec;
          m_held_rd = m_rd;
        end
      end
      chk("busy", VW'(busy), VW'(inb));
      chk("stall", VW'(stall), VW'((!inb && (start_load || start_store)) ||
                                   (m_active && d >= 1 && d < m_len)));
      chk("done", VW'(done), VW'(e_done));
      chk("load_valid", VW'(load_valid), VW'(e_done && m_load));
      chk("mem_wren", VW'(mem_wren), VW'(m_active && !m_load && d >= 1 && d <= m_n));
      chk("access_count", VW'(access_count), VW'(32'(m_count)));
      chk("load_data", load_data, m_held);
      chk("load_rd", VW'(load_rd), VW'(m_held_rd));
      if (m_active && d >= 1 && d <= m_n) begin
        ea = m_base + ADDR_W'(d - 1);
        chk("mem_addr", VW'(mem_addr), VW'(ea));
        if (!m_load) begin
          chk("mem_wdata", VW'(mem_wdata), VW'(m_data[(d-1)*ELEM_W +: ELEM_W]));
          model_mem[int'(ea)] = m_data[(d-1)*ELEM_W +: ELEM_W];
        end
      end
      if (done) last_done_cyc = cyc;
      if (mem_wren) wren_cycles++;
      if (stall) stall_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [VW-1:0] ramp_vec(input logic [15:0] first);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ELEM_W +: ELEM_W] = first + 16'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sl, input bit ss, input bit sc, input logic [ADDR_W-1:0] b,
                       input logic [4:0] r, input logic [VW-1:0] dat);
    start_load  = sl;
    start_store = ss;
    scalar_mode = sc;
    base_addr   = b;
    rd_in       = r;
    store_data  = dat;
    model_accept();
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), ADDR_W'($urandom()), 5'($urandom()), rand_vec());
  endtask

  task automatic issue(input bit sl, input bit ss, input bit sc, input logic [ADDR_W-1:0] b,
                       input logic [4:0] r, input logic [VW-1:0] dat, output int t);
    tick();
    drive(sl, ss, sc, b, r, dat);
    t = cyc;
  endtask

  task automatic run_until_idle();
    for (int k = 0; k < 200; k++) begin
      tick();
      idle_in();
      if (!m_active || cyc > m_t + m_len) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int t;
    int w0;
    int s0;
    logic [VW-1:0] exp_v;
    logic [ADDR_W-1:0] a;

    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("reset_count", VW'(access_count), '0);
    chk("reset_busy", VW'(busy), '0);

    // Vector store 0x100, lanes 0xA000+i.
    w0 = wren_cycles;
    issue(1'b0, 1'b1, 1'b0, 19'h100, 5'd0, ramp_vec(16'hA000), t);
    run_until_idle();
    chk("vst_wren_cycles", VW'(wren_cycles - w0), VW'(16));
    chk("vst_done_cycle", VW'(last_done_cyc), VW'(t + 17));
    chk("vst_count", VW'(access_count), VW'(1));
    for (int i = 0; i < LANES; i++)
      chk("vst_word", VW'(env_word(32'h100 + i)), VW'(16'hA000 + 16'(i)));

    // Vector load 0x20, rd 5, word(addr) = addr[15:0].
    s0 = stall_cycles;
    issue(1'b1, 1'b0, 1'b0, 19'h20, 5'd5, rand_vec(), t);
    run_until_idle();
    chk("vld_done_cycle", VW'(last_done_cyc), VW'(t + 19));
    chk("vld_stall_cycles", VW'(stall_cycles - s0), VW'(19));
    chk("vld_rd", VW'(load_rd), VW'(5));
    for (int i = 0; i < LANES; i++)
      chk("vld_lane", VW'(load_data[i*ELEM_W +: ELEM_W]), VW'(16'h20 + 16'(i)));

    // Scalar load at the top address.
    issue(1'b1, 1'b0, 1'b1, 19'h7FFFF, 5'd3, rand_vec(), t);
    run_until_idle();
    exp_v = '0;
    exp_v[15:0] = 16'hFFFF;
    chk("sld_data", load_data, exp_v);
    chk("sld_done_cycle", VW'(last_done_cyc), VW'(t + 4));

    // Vector store wrapping past the top of the address space.
    issue(1'b0, 1'b1, 1'b0, 19'h7FFFE, 5'd0, ramp_vec(16'hB000), t);
    run_until_idle();
    for (int i = 0; i < LANES; i++) begin
      a = 19'h7FFFE + 19'(i);
      chk("wrap_word", VW'(env_word(int'(a))), VW'(16'hB000 + 16'(i)));
    end
    chk("wrap_low_addr", VW'(env_word(13)), VW'(16'hB00F));

    // Both starts together, then starts pulsed while busy (incl. DONE).
    w0 = wren_cycles;
    issue(1'b1, 1'b1, 1'b0, 19'h300, 5'd7, rand_vec(), t);
    for (int k = 0; k < 200; k++) begin
      tick();
      if (cyc == t + 2 || cyc == t + 10 || cyc == t + m_len)
        drive(1'b1, 1'b1, 1'b0, 19'h5, 5'd9, rand_vec());
      else
        idle_in();
      if (cyc > t + m_len) break;
    end
    chk("both_no_writes", VW'(wren_cycles - w0), '0);
    chk("both_count", VW'(access_count), VW'(5));
    chk("both_rd", VW'(load_rd), VW'(7));

    // Reset in the middle of beat 5 of a store.
    issue(1'b0, 1'b1, 1'b0, 19'h60000, 5'd0, ramp_vec(16'hC000), t);
    for (int k = 0; k < 6; k++) begin
      tick();
      idle_in();
    end
    rst = 1'b0;
    m_active = 1'b0;
    m_count = 0;
    m_held = '0;
    m_held_rd = '0;
    #1;
    chk("abort_wren", VW'(mem_wren), '0);
    chk("abort_busy", VW'(busy), '0);
    chk("abort_stall", VW'(stall), '0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("abort_count", VW'(access_count), '0);
    chk("abort_word4", VW'(env_word(32'h60004)), VW'(16'hC004));
    chk("abort_word5", VW'(env_word(32'h60005)), VW'(16'h0005));

    // Random traffic: starts land both while idle and while busy.
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 3) == 0) a = 19'h7FFF0 + 19'($urandom_range(0, 15));
        else a = 19'($urandom_range(0, 511));
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) == 0, a, 5'($urandom()), rand_vec());
      end else begin
        idle_in();
      end
    end
    run_until_idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
